vote_collector: RTL and testbench

Upstream feeder for the 5-input majority voter. Accepts single-bit votes one per handshake from a serial source and assembles them into a NUM_VOTES-wide vote vector, with vote 0 in bit 0 driving pi0, vote 1 driving pi1, and so on. Presents each complete vector, plus its ones-count, to the downstream voter stage over a valid/ready handshake. An optional timeout discards stale partial frames.

---
 rtl/vote_collector_pkg.sv | 19 +
 rtl/vote_popcount.sv | 25 ++
 rtl/vote_collector.sv | 154 +++++++++++++++
 tb/tb_vote_collector.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_collector_pkg.sv
// Shared types and constants for the vote collector slice.
// The optional stale-frame timeout is enabled by defining VOTE_TIMEOUT_EN.
package vote_collector_pkg;

    // Collector FSM: gather votes, then hold the finished vector for downstream.
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    localparam int DEF_NUM_VOTES      = 5;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Width needed to hold a ones-count in the range 0..num_votes.
    function automatic int ones_width(input int num_votes);
        return $clog2(num_votes + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational ones-count over a vote vector; the parent registers the result.
module vote_popcount
    import vote_collector_pkg::*;
#(
    parameter int NUM_VOTES = DEF_NUM_VOTES
) (
    input  logic [NUM_VOTES-1:0]             votes_i,
    output logic [ones_width(NUM_VOTES)-1:0] ones_o
);

    localparam int OW = ones_width(NUM_VOTES);

    logic [OW-1:0] ones_s;

    // Sum the individual vote bits.
    always_comb begin
        ones_s = '0;
        for (int i = 0; i < NUM_VOTES; i++) begin
            ones_s = ones_s + OW'(votes_i[i]);
        end
    end

    assign ones_o = ones_s;

endmodule

// File: rtl/vote_collector.sv
// Serial vote collector: packs NUM_VOTES single-bit votes (vote i -> bit i)
// into a vector and hands it, with its ones-count, to the voter stage over a
// valid/ready handshake. Define VOTE_TIMEOUT_EN to discard partial frames
// that sit idle for TIMEOUT_CYCLES cycles.
module vote_collector
    import vote_collector_pkg::*;
#(
    parameter int NUM_VOTES      = DEF_NUM_VOTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             in_vote,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_VOTES-1:0]             out_votes,
    output logic [ones_width(NUM_VOTES)-1:0] out_ones,
    output logic                             timeout
);

    localparam int CW = $clog2(NUM_VOTES);
    localparam int OW = ones_width(NUM_VOTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_VOTES - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_VOTES-1:0] vec_q, vec_d;
    logic [OW-1:0]        ones_q, ones_d;
    logic [OW-1:0]        pop_s;
    logic                 accept_s;
    logic                 expire_s;

    // Ready is a pure function of state (held low during reset), so
    // out_ready never reaches in_ready combinationally.
    assign in_ready = (state_q == ST_COLLECT) && !rst;
    assign accept_s = in_valid && in_ready;

`ifdef VOTE_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_q, idle_d;
    logic        timeout_q;

    // A partial frame expires when its idle budget is spent and no vote arrives.
    assign expire_s = (state_q == ST_COLLECT) && !accept_s &&
                      (cnt_q != '0) && (idle_q == IDLE_LAST);

    // Idle counter runs only while a partial frame waits for its next vote.
    always_comb begin
        idle_d = idle_q;
        if ((state_q != ST_COLLECT) || accept_s || (cnt_q == '0) || expire_s) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 16'd1;
        end
    end

    // Idle counter and one-cycle timeout pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= expire_s;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg_s;

    assign expire_s             = 1'b0;
    assign timeout              = 1'b0;
    assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 1);
`endif

    // Next-state logic for the FSM, vote slot counter and vector register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    vec_d[cnt_q] = in_vote;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (expire_s) begin
                    cnt_d = '0;
                    vec_d = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_COLLECT;
                    vec_d   = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
                vec_d   = '0;
            end
        endcase
    end

    vote_popcount #(
        .NUM_VOTES (NUM_VOTES)
    ) u_popcount (
        .votes_i (vec_d),
        .ones_o  (pop_s)
    );

    // Capture the ones-count of the final vector as the frame enters HOLD.
    always_comb begin
        ones_d = ones_q;
        if ((state_q == ST_COLLECT) && (state_d == ST_HOLD)) begin
            ones_d = pop_s;
        end else begin
            ones_d = ones_q;
        end
    end

    // Main state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            vec_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            ones_q  <= ones_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_votes = vec_q;
    assign out_ones  = ones_q;

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_vote_collector;

    localparam int NV = 5;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_vote, out_ready;
    logic       in_ready, out_valid, timeout;
    logic [4:0] out_votes;
    logic [2:0] out_ones;

    logic       in_valid3, in_vote3, out_ready3;
    logic       in_ready3, out_valid3, timeout3;
    logic [2:0] out_votes3;
    logic [1:0] out_ones3;

    int total = 0;
    int bad   = 0;

    // Reference model: votes of the frame being collected, plus the held frame.
    bit         mq[$];
    bit         m_pending;
    logic [4:0] m_frame;
    int         m_ones;
    bit         m_to;
    int         cyc;
    int         last_acc;

    always #5 clk = ~clk;

    vote_collector #(.NUM_VOTES(NV), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vote(in_vote),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_votes(out_votes), .out_ones(out_ones), .timeout(timeout)
    );

    vote_collector #(.NUM_VOTES(3), .TIMEOUT_CYCLES(TO)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_vote(in_vote3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_votes(out_votes3), .out_ones(out_ones3), .timeout(timeout3)
    );

    function automatic logic [4:0] qvec();
        logic [4:0] v = 5'b00000;
        for (int i = 0; i < mq.size(); i++) v[i] = mq[i];
        return v;
    endfunction

    function automatic logic [4:0] exp_votes();
        return m_pending ? m_frame : qvec();
    endfunction

    // Drive one cycle of inputs, advance the model, step past the edge.
    task automatic tick(input bit v, input bit vote, input bit ordy, output bit acc);
        in_valid  = v;
        in_vote   = vote;
        out_ready = ordy;
        acc  = v && !m_pending;
        m_to = 1'b0;
        cyc++;
        if (m_pending) begin
            if (ordy) m_pending = 1'b0;
        end else if (acc) begin
            mq.push_back(vote);
            last_acc = cyc;
            if (mq.size() == NV) begin
                m_frame   = qvec();
                m_ones    = 0;
                foreach (mq[i]) if (mq[i]) m_ones++;
                m_pending = 1'b1;
                mq.delete();
            end
        end else if (mq.size() > 0) begin
`ifdef VOTE_TIMEOUT_EN
            if (cyc - last_acc == TO) begin
                mq.delete();
                m_to = 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b0;
        @(posedge clk);
        #1;
        mq.delete(); m_pending = 1'b0; m_to = 1'b0; cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_vote = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_votes !== 5'b00000) begin bad++; $display("FAIL reset_out_votes got=%b want=00000", out_votes); end
        total++; if (out_ones !== 3'd0) begin bad++; $display("FAIL reset_out_ones got=%0d want=0", out_ones); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        mq.delete(); m_pending = 1'b0; m_to = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_hold_stable();
        bit hv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        bit acc;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, hv[i], 1'b0, acc);
            total++; if (out_valid !== (i == 4)) begin bad++; $display("FAIL hold_latency vote=%0d got=%b want=%b", i, out_valid, (i == 4)); end
        end
        total++; if (out_votes !== 5'b01011) begin bad++; $display("FAIL hold_votes got=%b want=01011", out_votes); end
        total++; if (out_ones !== 3'd3) begin bad++; $display("FAIL hold_ones got=%0d want=3", out_ones); end
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, acc);
            total++;
            if ({out_valid, in_ready, out_votes, out_ones} !== {1'b1, 1'b0, 5'b01011, 3'd3}) begin
                bad++; $display("FAIL hold_stable cyc=%0d got=%b%b_%b_%0d want=10_01011_3", k, out_valid, in_ready, out_votes, out_ones);
            end
        end
        tick(1'b0, 1'b0, 1'b1, acc);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b want=1", in_ready); end
        total++; if (out_votes !== 5'b00000) begin bad++; $display("FAIL hold_release_votes got=%b want=00000", out_votes); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int rise = -1;
        bit acc;
        bit prev_valid = 1'b0;
        logic [4:0] seen[$];
        for (int c = 0; c < 14; c++) begin
            tick(1'b1, (k % 2 == 0), 1'b1, acc);
            if (acc) k++;
            if (out_valid === 1'b1 && !prev_valid) begin
                seen.push_back(out_votes);
                if (rise < 0) rise = c;
            end
            prev_valid = (out_valid === 1'b1);
            total++;
            if ({out_valid, in_ready} !== {m_pending, !m_pending} || out_votes !== exp_votes()) begin
                bad++; $display("FAIL b2b_cycle c=%0d got=%b%b_%b want=%b%b_%b", c, out_valid, in_ready, out_votes, m_pending, !m_pending, exp_votes());
            end
        end
        total++; if (rise != 4) begin bad++; $display("FAIL b2b_first_rise got=%0d want=4", rise); end
        total++; if (seen.size() < 2) begin bad++; $display("FAIL b2b_frame_count got=%0d want=2", seen.size()); end
        if (seen.size() >= 2) begin
            total++; if (seen[0] !== 5'b10101) begin bad++; $display("FAIL b2b_frame0 got=%b want=10101", seen[0]); end
            total++; if (seen[1] !== 5'b01010) begin bad++; $display("FAIL b2b_frame1 got=%b want=01010", seen[1]); end
        end
    endtask

    task automatic test_random();
        int gap = $urandom_range(0, 5);
        bit cur = 1'($urandom_range(0, 1));
        bit acc, v;
        bit prev_valid = 1'b0;
        int dut_frames = 0;
        int mdl_frames = 0;
        for (int c = 0; c < 400; c++) begin
            v = (gap == 0);
            if (gap > 0) gap--;
            tick(v, cur, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                gap = $urandom_range(0, 5);
                cur = 1'($urandom_range(0, 1));
            end
            if (m_pending && acc) mdl_frames++;
            if (out_valid === 1'b1 && !prev_valid) dut_frames++;
            prev_valid = (out_valid === 1'b1);
            total++;
            if ({out_valid, in_ready, timeout} !== {m_pending, !m_pending, m_to} || out_votes !== exp_votes()) begin
                bad++; $display("FAIL rand_cycle c=%0d got=%b%b%b_%b want=%b%b%b_%b", c, out_valid, in_ready, timeout, out_votes, m_pending, !m_pending, m_to, exp_votes());
            end
            if (m_pending) begin
                total++; if (out_ones !== 3'(m_ones)) begin bad++; $display("FAIL rand_ones c=%0d got=%0d want=%0d", c, out_ones, m_ones); end
            end
        end
        total++; if (dut_frames != mdl_frames || mdl_frames == 0) begin bad++; $display("FAIL rand_frames got=%0d want=%0d", dut_frames, mdl_frames); end
    endtask

    task automatic test_timeout();
        bit acc;
        int pulses = 0;
        apply_reset();
        rst = 1'b0;
        tick(1'b1, 1'b1, 1'b0, acc);
        tick(1'b1, 1'b1, 1'b0, acc);
`ifdef VOTE_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, acc);
            if (timeout === 1'b1) pulses++;
            total++; if (timeout !== (i == 7) || timeout !== m_to) begin bad++; $display("FAIL to_pulse idle=%0d got=%b want=%b", i, timeout, (i == 7)); end
            total++; if (out_votes !== ((i >= 7) ? 5'b00000 : 5'b00011)) begin bad++; $display("FAIL to_votes idle=%0d got=%b", i, out_votes); end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL to_pulse_count got=%0d want=1", pulses); end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, acc);
`else
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b0, acc);
            if (timeout === 1'b1) pulses++;
            total++; if (out_votes !== 5'b00011 || in_ready !== 1'b1) begin bad++; $display("FAIL to_wait idle=%0d got=%b_%b want=00011_1", i, out_votes, in_ready); end
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL to_pulse_count got=%0d want=0", pulses); end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, acc);
`endif
        total++; if (out_valid !== 1'b1 || out_votes !== 5'b11111) begin bad++; $display("FAIL to_frame got=%b_%b want=1_11111", out_valid, out_votes); end
        total++; if (out_ones !== 3'd5) begin bad++; $display("FAIL to_ones got=%0d want=5", out_ones); end
        tick(1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit v;
        tick(1'b1, 1'b1, 1'b0, acc); tick(1'b1, 1'b0, 1'b0, acc); tick(1'b1, 1'b1, 1'b0, acc);
        total++; if (out_votes !== 5'b00101) begin bad++; $display("FAIL rmid_partial got=%b want=00101", out_votes); end
        apply_reset();
        total++; if ({out_valid, out_votes, timeout, in_ready} !== 8'b0_00000_0_0) begin bad++; $display("FAIL rmid_collect got=%b_%b_%b_%b want=0_00000_0_0", out_valid, out_votes, timeout, in_ready); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b0, acc);
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rmid_no_timeout i=%0d got=%b want=0", i, timeout); end
        end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, acc);
        total++; if (out_valid !== 1'b1 || out_votes !== exp_votes()) begin bad++; $display("FAIL rmid_frame1 got=%b_%b want=1_%b", out_valid, out_votes, exp_votes()); end
        apply_reset();
        total++; if ({out_valid, out_votes, timeout} !== 7'b0_00000_0) begin bad++; $display("FAIL rmid_hold got=%b_%b_%b want=0_00000_0", out_valid, out_votes, timeout); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = 1'($urandom_range(0, 1));
            tick(1'b1, v, 1'b0, acc);
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rmid_fresh_timeout i=%0d got=%b want=0", i, timeout); end
        end
        total++; if (out_valid !== 1'b1 || out_votes !== m_frame || out_ones !== 3'(m_ones)) begin bad++; $display("FAIL rmid_fresh got=%b_%b_%0d want=1_%b_%0d", out_valid, out_votes, out_ones, m_frame, m_ones); end
        tick(1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_nv3();
        bit v3[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1; in_vote3 = v3[i]; out_ready3 = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid3 = 1'b0;
        total++; if (out_valid3 !== 1'b1 || in_ready3 !== 1'b0) begin bad++; $display("FAIL nv3_valid got=%b%b want=10", out_valid3, in_ready3); end
        total++; if (out_votes3 !== 3'b100) begin bad++; $display("FAIL nv3_votes got=%b want=100", out_votes3); end
        total++; if (out_ones3 !== 2'd1) begin bad++; $display("FAIL nv3_ones got=%0d want=1", out_ones3); end
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        out_ready3 = 1'b0;
        total++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1 || timeout3 !== 1'b0) begin bad++; $display("FAIL nv3_release got=%b%b%b want=010", out_valid3, in_ready3, timeout3); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vote = 1'b0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_vote3 = 1'b0; out_ready3 = 1'b0;
        cyc = 0; last_acc = 0; m_pending = 1'b0; m_to = 1'b0; m_ones = 0; m_frame = 5'b00000;
        test_reset();
        test_hold_stable();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        test_nv3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
